// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, default widths and FSM states.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 2;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_pick2 (
    input  logic [1:0] i_req_valid,
    input  logic       i_last_grant,
    output logic       o_winner,
    output logic       o_any
);

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        o_winner = 1'b0;
        o_any    = |i_req_valid;
        case (i_req_valid)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = ~i_last_grant;
            default: o_winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters. Optional macro ALU_ARBITER_LOCK_EN adds req_lock to hold priority.
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
`ifdef ALU_ARBITER_LOCK_EN
    input  logic [1:0]        req_lock,
`endif
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_z,
    output logic              resp_agb,
    output logic              resp_bga,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_agb,
    input  logic              alu_bga,
    output logic              busy
);

    import alu_pkg::*;

    alu_arb_state_t      r_state;
    alu_arb_state_t      w_state_nxt;
    logic                r_owner;
    logic                r_last_grant;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_op;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_z;
    logic                r_resp_agb;
    logic                r_resp_bga;
    logic [1:0]          r_resp_valid;
    logic                w_winner;
    logic                w_any;
    logic                w_accept;
    logic                w_resp_done;
    logic                w_hold_grant;

    rr_pick2 u_pick (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    assign w_accept    = (r_state == ST_IDLE) && w_any;
    assign w_resp_done = (r_state == ST_RESP) && resp_ready[r_owner];

`ifdef ALU_ARBITER_LOCK_EN
    logic r_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if (w_accept) begin
            r_lock <= req_lock[w_winner];
        end
    end

    assign w_hold_grant = r_lock;
`else
    assign w_hold_grant = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready[w_winner] = 1'b1;
                    w_state_nxt         = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (w_resp_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: every datapath register is reset so a mid-operation reset drops
    // the in-flight operation without leaving stale responses behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_resp_data  <= '0;
            r_resp_z     <= 1'b0;
            r_resp_agb   <= 1'b0;
            r_resp_bga   <= 1'b0;
            r_resp_valid <= 2'b00;
        end else begin
            if (w_accept) begin
                r_owner  <= w_winner;
                r_alu_op <= w_winner ? req1_op : req0_op;
                r_alu_a  <= w_winner ? req1_a  : req0_a;
                r_alu_b  <= w_winner ? req1_b  : req0_b;
            end
            if (r_state == ST_EXEC) begin
                r_resp_data  <= alu_result;
                r_resp_z     <= alu_z;
                r_resp_agb   <= alu_agb;
                r_resp_bga   <= alu_bga;
                r_resp_valid <= r_owner ? 2'b10 : 2'b01;
            end
            if (w_resp_done) begin
                r_resp_valid <= 2'b00;
                // A locked owner keeps tie priority for its follow-up operation.
                if (!w_hold_grant) begin
                    r_last_grant <= r_owner;
                end
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign resp_data  = r_resp_data;
    assign resp_z     = r_resp_z;
    assign resp_agb   = r_resp_agb;
    assign resp_bga   = r_resp_bga;
    assign resp_valid = r_resp_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, per-requester scoreboards
// and hand-written sequences for back-pressure, reset and lock corner cases.
module tb_alu_arbiter;

    import alu_pkg::*;

    localparam int DW = 16;
    localparam int OW = 2;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] data;
        logic          z;
        logic          agb;
        logic          bga;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid, req_ready, resp_valid, resp_ready, req_lock;
    logic [OW-1:0] req0_op, req1_op, alu_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [DW-1:0] resp_data, alu_a, alu_b, alu_result;
    logic          resp_z, resp_agb, resp_bga, alu_z, alu_agb, alu_bga, busy;

    vec_t   vecs [8];
    vec_t   exp_q0 [$];
    vec_t   exp_q1 [$];
    logic   grant_log [$];
    int     accept_cyc [$];
    int     cur_idx [2];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef ALU_ARBITER_LOCK_EN
        .req_lock   (req_lock),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_z     (resp_z),
        .resp_agb   (resp_agb),
        .resp_bga   (resp_bga),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .alu_agb    (alu_agb),
        .alu_bga    (alu_bga),
        .busy       (busy)
    );

    // The shared external ALU.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
        alu_z   = (alu_result == '0);
        alu_agb = (alu_a > alu_b);
        alu_bga = (alu_b > alu_a);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    initial begin
        vec_t v;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    if (req_valid[k] && req_ready[k]) begin
                        grant_log.push_back(1'(k));
                        accept_cyc.push_back(cyc);
                        if (k == 0) exp_q0.push_back(vecs[cur_idx[0]]);
                        else        exp_q1.push_back(vecs[cur_idx[1]]);
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (resp_valid[k] && resp_ready[k]) begin
                        check("resp_owner_onehot", resp_valid, (k == 0) ? 2'b01 : 2'b10);
                        check("resp_expected", (k == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0), 1);
                        if ((k == 0 && exp_q0.size() != 0) || (k == 1 && exp_q1.size() != 0)) begin
                            v = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            check("resp_data", resp_data, v.data);
                            check("resp_flags", {resp_z, resp_agb, resp_bga}, {v.z, v.agb, v.bga});
                        end
                    end
                end
            end
        end
    end

    task automatic drive_req(input int k, input int idx, input logic lock);
        int n = 0;
        cur_idx[k] = idx;
        if (k == 0) begin
            req0_op = vecs[idx].op; req0_a = vecs[idx].a; req0_b = vecs[idx].b;
        end else begin
            req1_op = vecs[idx].op; req1_a = vecs[idx].a; req1_b = vecs[idx].b;
        end
        req_lock[k]  = lock;
        req_valid[k] = 1'b1;
        while (1) begin
            @(negedge clk);
            if (req_ready[k] || n >= 100) break;
            n++;
        end
        check("accept_in_time", (n < 100), 1);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_lock[k]  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 60 && (busy || exp_q0.size() != 0 || exp_q1.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        check("idle_in_time", (n < 60), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int n;
        vecs[0] = '{ALU_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{ALU_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{ALU_SUB, 16'h8000, 16'h0001, 16'h7fff, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{ALU_AND, 16'hf0f0, 16'hff00, 16'hf000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{ALU_OR,  16'h00f0, 16'h0f00, 16'h0ff0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{ALU_ADD, 16'hffff, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{ALU_AND, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{ALU_OR,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b11; req_lock = 2'b00;
        req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
        cur_idx[0] = 0; cur_idx[1] = 0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state and combinational ready.
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_alu_a", alu_a, 0);
        check("rst_req_ready_idle", req_ready, 2'b00);
        req_valid = 2'b01;
        #1;
        check("req_ready_comb", req_ready, 2'b01);
        req_valid = 2'b00;
        @(posedge clk); #1;

        // Table: single requests alternating between requesters, with latency.
        for (int i = 0; i < 8; i++) begin
            drive_req(i % 2, i, 1'b0);
            check("exec_no_resp", resp_valid, 2'b00);
            check("exec_busy", busy, 1);
            @(posedge clk); #1;
            check("resp_latency", resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
            wait_idle();
        end

        // Both valid continuously: strict alternation, 3-cycle issue interval.
        g0 = grant_log.size();
        fork
            begin
                drive_req(0, 0, 1'b0); drive_req(0, 1, 1'b0);
                drive_req(0, 4, 1'b0); drive_req(0, 6, 1'b0);
            end
            begin
                drive_req(1, 2, 1'b0); drive_req(1, 3, 1'b0);
                drive_req(1, 5, 1'b0); drive_req(1, 7, 1'b0);
            end
        join
        wait_idle();
        check("rr_count", grant_log.size() - g0, 8);
        for (int i = 0; i < 8 && g0 + i < grant_log.size(); i++) begin
            check("rr_order", grant_log[g0 + i], (i % 2 == 0) ? 1'b0 : 1'b1);
            if (i > 0) check("rr_interval", accept_cyc[g0 + i] - accept_cyc[g0 + i - 1], 3);
        end

        // Back-pressure on requester 1 while requester 0 waits.
        resp_ready = 2'b01;
        g0 = grant_log.size();
        drive_req(1, 2, 1'b0);
        fork
            drive_req(0, 4, 1'b0);
        join_none
        n = 0;
        while (!resp_valid[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp_seen", resp_valid, 2'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_data_stable", resp_data, vecs[2].data);
            check("bp_req_ready", req_ready, 2'b00);
            check("bp_busy", busy, 1);
        end
        @(posedge clk); #1;
        resp_ready = 2'b11;
        wait fork;
        wait_idle();
        check("bp_grant_count", grant_log.size() - g0, 2);
        check("bp_next_is_req0", grant_log[grant_log.size() - 1], 0);

        // Reset pulsed while the operation is in EXEC.
        drive_req(0, 1, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alu_a", alu_a, 0);
        rst_n = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_resp", resp_valid, 2'b00);
            check("mid_rst_idle", busy, 0);
        end
        @(posedge clk); #1;
        g0 = grant_log.size();
        fork
            drive_req(0, 6, 1'b0);
            drive_req(1, 7, 1'b0);
        join
        wait_idle();
        check("post_rst_tie_req0", grant_log[g0], 0);
        check("post_rst_then_req1", grant_log[g0 + 1], 1);

`ifdef ALU_ARBITER_LOCK_EN
        // Locked requester 1 wins the following tie, then alternation resumes.
        drive_req(0, 0, 1'b0);
        wait_idle();
        drive_req(1, 3, 1'b1);
        wait_idle();
        g0 = grant_log.size();
        fork
            begin drive_req(0, 4, 1'b0); drive_req(0, 6, 1'b0); end
            begin drive_req(1, 5, 1'b0); drive_req(1, 7, 1'b0); end
        join
        wait_idle();
        check("lock_first", grant_log[g0 - 1], 1);
        check("lock_second", grant_log[g0], 1);
        check("lock_alt0", grant_log[g0 + 1], 0);
        check("lock_alt1", grant_log[g0 + 2], 1);
        check("lock_alt2", grant_log[g0 + 3], 0);
`endif

        check("sb_empty", exp_q0.size() + exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
